// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow flag.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             b_in;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] D;
  logic             b_out;
  logic             busy;
  logic             done;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, b_in, A, B, input D, b_out, busy, done, ovf);
  modport slave  (input start, b_in, A, B, output D, b_out, busy, done, ovf);
`else
  modport master (output start, b_in, A, B, input D, b_out, busy, done);
  modport slave  (input start, b_in, A, B, output D, b_out, busy, done);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: D = A - B - b_in, LSB first,
// one bit per clock, start/busy/done handshake. Results are held until the
// next completion. Define SERIAL_SUB_OVF_EN to add the signed-overflow flag.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] ra, rb, rd;
  logic [WIDTH-1:0] d_q;
  logic             br, bo_q, busy_q, done_q;
  logic [CW-1:0]    cnt;

  // one full-subtractor cell on the current LSBs
  logic bit_a, bit_b, bit_d, br_nx, last;
  assign bit_a = ra[0];
  assign bit_b = rb[0];
  assign bit_d = bit_a ^ bit_b ^ br;
  assign br_nx = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br);
  assign last  = (cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUB_OVF_EN
  // operand sign bits survive here because ra/rb are shifted away
  logic a_msb, b_msb, ovf_q;
  assign bus.ovf = ovf_q;
`endif

  assign bus.D     = d_q;
  assign bus.b_out = bo_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

  // control FSM plus serial datapath; every output is a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ra     <= '0;
      rb     <= '0;
      rd     <= '0;
      d_q    <= '0;
      br     <= 1'b0;
      bo_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE falls through here so a held start runs back-to-back
          done_q <= 1'b0;
          if (bus.start) begin
            ra     <= bus.A;
            rb     <= bus.B;
            br     <= bus.b_in;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= bus.A[WIDTH-1];
            b_msb  <= bus.B[WIDTH-1];
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          // start is deliberately not looked at while shifting
          rd  <= {bit_d, rd[WIDTH-1:1]};
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          br  <= br_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            d_q    <= {bit_d, rd[WIDTH-1:1]};
            bo_q   <= br_nx;
`ifdef SERIAL_SUB_OVF_EN
            // bit_d is the result MSB produced this cycle
            ovf_q  <= (a_msb != b_msb) && (bit_d != a_msb);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed vectors.
// Define SERIAL_SUB_OVF_EN to also check the overflow flag.
module tb_serial_subtractor;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_subtractor_if #(.WIDTH(W)) sif ();
  serial_subtractor #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(sif.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[9];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic [W-1:0] prev_d;
  logic         prev_bo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_result(input string tag, input vec_t v);
    chk({tag, "_done"}, sif.done, 1);
    chk({tag, "_busy"}, sif.busy, 0);
    chk({tag, "_d"}, sif.D, v.d);
    chk({tag, "_bo"}, sif.b_out, v.bo);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, sif.ovf, v.ov);
`endif
  endtask

  // one op, checking busy/done/hold every cycle; returns at the negedge after DONE
  task automatic run_op(input vec_t v);
    @(negedge clk);
    sif.A = v.a; sif.B = v.b; sif.b_in = v.bin; sif.start = 1'b1;
    @(negedge clk);                      // cycle 1
    sif.start = 1'b0;
    sif.A = ~v.a; sif.B = ~v.b; sif.b_in = ~v.bin;  // must not matter
    for (int c = 1; c <= W; c++) begin
      if (c > 1) @(negedge clk);
      chk("busy", sif.busy, 1);
      chk("done_lo", sif.done, 0);
      chk("d_hold", sif.D, prev_d);
      chk("bo_hold", sif.b_out, prev_bo);
    end
    @(negedge clk);                      // cycle W+1
    chk_result("res", v);
    prev_d = v.d; prev_bo = v.bo;
    @(negedge clk);
    chk("pulse_end", sif.done, 0);
    chk("d_keep", sif.D, v.d);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    //            a      b     bin   d      bo    ov
    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1};
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1};
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[4] = '{4'h7, 4'hF, 1'b0, 4'h8, 1'b1, 1'b1};
    vecs[5] = '{4'h5, 4'h2, 1'b0, 4'h3, 1'b0, 1'b0};
    vecs[6] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[7] = '{4'h6, 4'h6, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[8] = '{4'h0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0};

    sif.start = 1'b0; sif.b_in = 1'b0; sif.A = '0; sif.B = '0;
    prev_d = '0; prev_bo = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_d", sif.D, 0);
    chk("rst_bo", sif.b_out, 0);
    chk("rst_busy", sif.busy, 0);
    chk("rst_done", sif.done, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", sif.ovf, 0);
`endif
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 9; i++) run_op(vecs[i]);

    // start re-pulsed in cycle 2 with other operands: ignored
    @(negedge clk);
    sif.A = 4'h9; sif.B = 4'h3; sif.b_in = 1'b0; sif.start = 1'b1;
    @(negedge clk); sif.start = 1'b0;                    // cycle 1
    @(negedge clk); sif.A = 4'h2; sif.B = 4'h1; sif.start = 1'b1;  // cycle 2
    @(negedge clk); sif.start = 1'b0;                    // cycle 3
    chk("ign_busy", sif.busy, 1);
    @(negedge clk);                                      // cycle 4
    @(negedge clk);                                      // cycle 5
    chk_result("ign", vecs[0]);
    for (int c = 6; c < 14; c++) begin
      @(negedge clk);
      chk("ign_one_done", sif.done, 0);
      chk("ign_idle", sif.busy, 0);
    end
    chk("ign_d_keep", sif.D, 4'h6);

    // start held high: done every W+1 cycles, each with its own operands
    @(negedge clk);
    sif.A = vecs[1].a; sif.B = vecs[1].b; sif.b_in = vecs[1].bin; sif.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int c = 1; c <= W + 1; c++) begin
        @(negedge clk);
        if (c == 1 && k < 2) begin
          sif.A = vecs[k + 2].a; sif.B = vecs[k + 2].b; sif.b_in = vecs[k + 2].bin;
        end
        if (c <= W) begin
          chk("b2b_busy", sif.busy, 1);
          chk("b2b_done_lo", sif.done, 0);
        end else begin
          chk_result("b2b", vecs[k + 1]);
          if (k == 2) sif.start = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("b2b_stop_busy", sif.busy, 0);
    chk("b2b_stop_done", sif.done, 0);
    chk("b2b_last_d", sif.D, vecs[3].d);

    // reset in cycle 3 aborts the op
    @(negedge clk);
    sif.A = 4'h9; sif.B = 4'h3; sif.b_in = 1'b0; sif.start = 1'b1;
    @(negedge clk); sif.start = 1'b0;    // cycle 1
    @(negedge clk);                      // cycle 2
    @(negedge clk);                      // cycle 3
    rst_n = 1'b0;
    #1;
    chk("abort_d", sif.D, 0);
    chk("abort_bo", sif.b_out, 0);
    chk("abort_busy", sif.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort_no_done", sif.done, 0);
      chk("abort_no_busy", sif.busy, 0);
    end
    prev_d = '0; prev_bo = 1'b0;
    run_op(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
